// File: rtl/dlx_pkg.sv
// dlx_pkg: shared DLX definitions for the fetch slice.
//   XLEN             - datapath width
//   INSTR_NOP        - instruction word used for pipeline bubbles
//   DEFAULT_RESET_PC - default first fetch address after reset
//   fetch_entry_t    - buffered fetch result {instr, pc+4}
package dlx_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc_next;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding returned fetch words until ID takes them.
//   clk, reset_n - clock, synchronous active-low reset
//   clear_i      - drop all entries (takes priority over push/pop)
//   push_i       - write wdata_i (caller guarantees not full)
//   wdata_i      - entry to write
//   pop_i        - remove head (caller guarantees not empty)
//   rdata_o      - current head entry
//   count_o      - number of valid entries
module fetch_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 64
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic [Width-1:0]           wdata_i,
   input  logic                       pop_i,
   output logic [Width-1:0]           rdata_o,
   output logic [$clog2(Depth):0]     count_o
);

   localparam int unsigned PW = $clog2(Depth) + 1;
   localparam int unsigned AW = $clog2(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    count_q, count_d;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (clear_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) wptr_d = ptr_inc(wptr_q);
         if (pop_i)  rptr_d = ptr_inc(rptr_q);
         count_d = count_q + PW'(push_i) - PW'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !clear_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q[AW-1:0]];
   assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: DLX instruction-fetch stage. Owns the PC, issues in-order fetches,
// buffers returned words and loads the IF/ID register; handles EX redirects.
//   clk, reset_n          - clock, synchronous active-low reset
//   pc_cmd_EX, pc_in_EX   - redirect request and target from EX
//   stall_ID              - ID cannot accept an instruction this cycle
//   i_address             - fetch byte address (current PC)
//   i_read_enable/i_ready - fetch request / memory accepts it
//   i_data/i_valid        - in-order response word / response valid
//   instr_ID, PC_ID       - IF/ID instruction and its fetch address + 4
//   valid_ID              - IF/ID holds a live instruction
//   flush_ID              - kill the instruction in ID (same cycle as redirect)
module if_stage
   import dlx_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        pc_cmd_EX,
   input  logic [31:0] pc_in_EX,
   input  logic        stall_ID,
   output logic [31:0] i_address,
   output logic        i_read_enable,
   input  logic        i_ready,
   input  logic [31:0] i_data,
   input  logic        i_valid,
   output logic [31:0] instr_ID,
   output logic [31:0] PC_ID,
   output logic        valid_ID,
   output logic        flush_ID
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   resp_pc_q, resp_pc_d;   // address of the next non-dropped response
   logic [CW-1:0] live_q, live_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [31:0]   instr_q, instr_d;
   logic [31:0]   pc_id_q, pc_id_d;
   logic          valid_q, valid_d;

   logic [CW-1:0] buf_cnt;
   logic [CW+1:0] occupancy;
   logic          req_fire, resp_drop, resp_keep, bypass, fifo_push, fifo_pop;
   fetch_entry_t  resp_entry, head_entry;

   assign occupancy = {2'b00, live_q} + {2'b00, drop_q} + {2'b00, buf_cnt};

   assign i_read_enable = reset_n & ~pc_cmd_EX & (occupancy < (CW+2)'(FIFO_DEPTH));
   assign i_address     = pc_q;
   assign flush_ID      = pc_cmd_EX;

   assign req_fire  = i_read_enable & i_ready;
   assign resp_drop = i_valid & (drop_q != '0);
   assign resp_keep = i_valid & (drop_q == '0);

   assign resp_entry = '{instr: i_data, pc_next: resp_pc_q + 32'd4};

   // An empty buffer lets a response skip straight into IF/ID.
   assign bypass    = resp_keep & (buf_cnt == '0) & ~stall_ID & ~pc_cmd_EX;
   assign fifo_push = resp_keep & ~bypass & ~pc_cmd_EX;
   assign fifo_pop  = (buf_cnt != '0) & ~stall_ID & ~pc_cmd_EX;

   fetch_fifo #(
      .Depth (FIFO_DEPTH),
      .Width ($bits(fetch_entry_t))
   ) u_fetch_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_i (pc_cmd_EX),
      .push_i  (fifo_push),
      .wdata_i (resp_entry),
      .pop_i   (fifo_pop),
      .rdata_o (head_entry),
      .count_o (buf_cnt)
   );

   always_comb begin
      pc_d      = pc_q;
      resp_pc_d = resp_pc_q;
      live_d    = live_q;
      drop_d    = drop_q;
      instr_d   = instr_q;
      pc_id_d   = pc_id_q;
      valid_d   = valid_q;
      if (pc_cmd_EX) begin
         pc_d      = pc_in_EX & ~32'h3;
         resp_pc_d = pc_in_EX & ~32'h3;
         // Every request still outstanding after this edge must be discarded.
         drop_d    = drop_q + live_q - CW'(i_valid);
         live_d    = '0;
         instr_d   = INSTR_NOP;
         valid_d   = 1'b0;
      end else begin
         if (req_fire)  pc_d = pc_q + 32'd4;
         if (resp_keep) resp_pc_d = resp_pc_q + 32'd4;
         live_d = live_q + CW'(req_fire) - CW'(resp_keep);
         drop_d = drop_q - CW'(resp_drop);
         if (!stall_ID) begin
            if (buf_cnt != '0) begin
               instr_d = head_entry.instr;
               pc_id_d = head_entry.pc_next;
               valid_d = 1'b1;
            end else if (bypass) begin
               instr_d = resp_entry.instr;
               pc_id_d = resp_entry.pc_next;
               valid_d = 1'b1;
            end else begin
               instr_d = INSTR_NOP;
               valid_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pc_q      <= RESET_PC;
         resp_pc_q <= RESET_PC;
         live_q    <= '0;
         drop_q    <= '0;
         instr_q   <= INSTR_NOP;
         pc_id_q   <= '0;
         valid_q   <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         resp_pc_q <= resp_pc_d;
         live_q    <= live_d;
         drop_q    <= drop_d;
         instr_q   <= instr_d;
         pc_id_q   <= pc_id_d;
         valid_q   <= valid_d;
      end
   end

   assign instr_ID = instr_q;
   assign PC_ID    = pc_id_q;
   assign valid_ID = valid_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        pc_cmd_EX = 1'b0;
   logic [31:0] pc_in_EX = '0;
   logic        stall_ID = 1'b0;
   logic [31:0] i_address;
   logic        i_read_enable;
   logic        i_ready = 1'b1;
   logic [31:0] i_data = '0;
   logic        i_valid = 1'b0;
   logic [31:0] instr_ID;
   logic [31:0] PC_ID;
   logic        valid_ID;
   logic        flush_ID;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat = 1;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] due;
   } req_t;
   req_t pending[$];

   typedef struct packed {
      logic        stall;
      logic        re;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;
   vec_t vec[11];

   if_stage #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .pc_cmd_EX     (pc_cmd_EX),
      .pc_in_EX      (pc_in_EX),
      .stall_ID      (stall_ID),
      .i_address     (i_address),
      .i_read_enable (i_read_enable),
      .i_ready       (i_ready),
      .i_data        (i_data),
      .i_valid       (i_valid),
      .instr_ID      (instr_ID),
      .PC_ID         (PC_ID),
      .valid_ID      (valid_ID),
      .flush_ID      (flush_ID)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a ^ 32'hDEAD_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // One clock: record the accepted request, clock, then drive any due response.
   task automatic step();
      req_t r;
      #1;
      if (reset_n && i_read_enable && i_ready) begin
         r.addr = i_address;
         r.due  = 32'(cyc + lat);
         pending.push_back(r);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pending.size() > 0 && pending[0].due <= 32'(cyc)) begin
         r = pending.pop_front();
         i_valid = 1'b1;
         i_data  = memf(r.addr);
      end else begin
         i_valid = 1'b0;
         i_data  = '0;
      end
   endtask

   task automatic do_reset(input int l);
      lat       = l;
      reset_n   = 1'b0;
      pc_cmd_EX = 1'b0;
      stall_ID  = 1'b0;
      i_valid   = 1'b0;
      pending.delete();
      step();
      step();
      reset_n = 1'b1;
      cyc     = 0;
   endtask

   initial begin
      bit found;

      // cycle: stall, expected req, expected addr, expected valid/PC_ID after edge
      vec[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
      vec[1]  = '{1'b0, 1'b1, 32'h04, 1'b1, 32'h04};
      vec[2]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h08};
      vec[3]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h0C};
      vec[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C};
      vec[5]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h0C};
      vec[6]  = '{1'b1, 1'b0, 32'h14, 1'b1, 32'h0C};
      vec[7]  = '{1'b0, 1'b0, 32'h14, 1'b1, 32'h10};
      vec[8]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h14};
      vec[9]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h18};
      vec[10] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h1C};

      // Reset state
      reset_n = 1'b0;
      #1;
      chk("reset_re", 32'(i_read_enable), 32'd0);
      step();
      chk("reset_valid", 32'(valid_ID), 32'd0);
      chk("reset_pc_id", PC_ID, 32'h0);
      chk("reset_instr", instr_ID, NOP);
      chk("reset_addr", i_address, 32'h0);

      // Streaming with a 3-cycle stall, L=1
      do_reset(1);
      for (int k = 0; k < 11; k++) begin
         stall_ID = vec[k].stall;
         #1;
         chk($sformatf("stream_re[%0d]", k), 32'(i_read_enable), 32'(vec[k].re));
         if (vec[k].re) chk($sformatf("stream_addr[%0d]", k), i_address, vec[k].addr);
         step();
         chk($sformatf("stream_valid[%0d]", k), 32'(valid_ID), 32'(vec[k].valid));
         chk($sformatf("stream_pc[%0d]", k), PC_ID, vec[k].pc);
         chk($sformatf("stream_instr[%0d]", k), instr_ID,
             vec[k].valid ? memf(vec[k].pc - 32'd4) : NOP);
      end
      stall_ID = 1'b0;

      // L=3: at most two outstanding
      do_reset(3);
      for (int k = 0; k < 5; k++) begin
         logic [4:0] exp_re;
         exp_re = 5'b10011;  // bit k = expected request in cycle k
         #1;
         chk($sformatf("lat3_re[%0d]", k), 32'(i_read_enable), 32'(exp_re[k]));
         step();
      end

      // Redirect to 0x100 with two fetches in flight (L=3)
      do_reset(3);
      step();
      step();
      pc_cmd_EX = 1'b1;
      pc_in_EX  = 32'h100;
      #1;
      chk("redir_flush", 32'(flush_ID), 32'd1);
      chk("redir_re", 32'(i_read_enable), 32'd0);
      step();
      pc_cmd_EX = 1'b0;
      chk("redir_valid_after", 32'(valid_ID), 32'd0);
      chk("redir_flush_clear", 32'(flush_ID), 32'd0);
      chk("redir_addr", i_address, 32'h100);
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         step();
         if (valid_ID) found = 1'b1;
      end
      chk("redir_found", 32'(found), 32'd1);
      chk("redir_first_pc", PC_ID, 32'h104);
      chk("redir_first_instr", instr_ID, memf(32'h100));

      // Redirect to 0x203 with simultaneous response and stall (L=1)
      do_reset(1);
      step();
      step();
      chk("r2_pre_valid", 32'(valid_ID), 32'd1);
      chk("r2_pre_resp", 32'(i_valid), 32'd1);
      stall_ID  = 1'b1;
      pc_cmd_EX = 1'b1;
      pc_in_EX  = 32'h203;
      #1;
      chk("r2_flush", 32'(flush_ID), 32'd1);
      chk("r2_re", 32'(i_read_enable), 32'd0);
      step();
      stall_ID  = 1'b0;
      pc_cmd_EX = 1'b0;
      #1;
      chk("r2_valid_after", 32'(valid_ID), 32'd0);
      chk("r2_addr", i_address, 32'h200);
      chk("r2_re_next", 32'(i_read_enable), 32'd1);
      step();
      chk("r2_bubble", 32'(valid_ID), 32'd0);
      step();
      chk("r2_valid", 32'(valid_ID), 32'd1);
      chk("r2_pc", PC_ID, 32'h204);
      chk("r2_instr", instr_ID, memf(32'h200));

      // One-cycle reset mid-stream
      do_reset(1);
      for (int k = 0; k < 4; k++) step();
      reset_n = 1'b0;
      i_valid = 1'b0;
      pending.delete();
      #1;
      chk("mrst_re", 32'(i_read_enable), 32'd0);
      step();
      chk("mrst_valid", 32'(valid_ID), 32'd0);
      chk("mrst_pc_id", PC_ID, 32'h0);
      chk("mrst_instr", instr_ID, NOP);
      chk("mrst_addr", i_address, 32'h0);
      reset_n = 1'b1;
      cyc     = 0;
      #1;
      chk("mrst_re_after", 32'(i_read_enable), 32'd1);
      step();
      step();
      chk("mrst_refetch_valid", 32'(valid_ID), 32'd1);
      chk("mrst_refetch_pc", PC_ID, 32'h4);
      chk("mrst_refetch_instr", instr_ID, memf(32'h0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
